axi4lite_to_ahb_bridge: RTL and testbench

- Single-outstanding bridge that converts AXI4-Lite slave transactions into AHB-Lite master transfers.
- Sits directly downstream of the block's AXI4-Lite slave interface, which the AXI VIP master drives in the BFM example design.
- Drives the AHB-Lite bus towards the register/memory slaves.
- Handles one transfer at a time; alternates priority between reads and writes.

---
 rtl/axi4lite_to_ahb_bridge_if.sv | 71 +++++++
 rtl/axi4lite_to_ahb_bridge.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi4lite_to_ahb_bridge.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_to_ahb_bridge_if.sv
// AXI4-Lite slave and AHB-Lite master signal bundle
// for the AXI4-Lite to AHB-Lite bridge.
interface axi4lite_to_ahb_bridge_if #(
  parameter int C_ADDR_WIDTH = 32
);
  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [31:0]             S_AXI_WDATA;
  logic [3:0]              S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [31:0]             S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;
  logic [C_ADDR_WIDTH-1:0] HADDR;
  logic [1:0]              HTRANS;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [2:0]              HBURST;
  logic [3:0]              HPROT;
  logic [31:0]             HWDATA;
  logic [31:0]             HRDATA;
  logic                    HREADY;
  logic                    HRESP;

  // bridge side: AXI slave, AHB master
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP,
    output S_AXI_RVALID,
    input  S_AXI_RREADY,
    output HADDR, HTRANS, HWRITE, HSIZE,
    output HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  // environment side: AXI master, AHB slave
  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP,
    input  S_AXI_RVALID,
    output S_AXI_RREADY,
    input  HADDR, HTRANS, HWRITE, HSIZE,
    input  HBURST, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/axi4lite_to_ahb_bridge.sv
// Single-outstanding AXI4-Lite slave to AHB-Lite
// master bridge with read/write alternation.
module axi4lite_to_ahb_bridge #(
  parameter int          C_ADDR_WIDTH = 32,
  parameter int          C_DATA_WIDTH = 32,
  parameter logic [3:0]  C_HPROT      = 4'b0011
) (
  input logic ACLK,
  input logic ARESET,
  axi4lite_to_ahb_bridge_if.slave bus
);

  localparam int AW = C_ADDR_WIDTH;

  if (C_DATA_WIDTH != 32) begin : g_width_check
    $error("axi4lite_to_ahb_bridge: only 32-bit data");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WR_RESP,
    S_RD_RESP
  } state_t;

  state_t state, state_nx;

  logic          aw_full, w_full, ar_full;
  logic [AW-1:2] aw_addr, ar_addr;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          last_rd, cur_wr;

  logic          wr_pend, rd_pend;
  logic          pick_wr, pick_rd;
  logic          addr_done, data_done;
  logic          strb_ok;
  logic [2:0]    strb_size;
  logic [1:0]    strb_lo;

  logic          awready, wready, arready;
  logic          bvalid, rvalid;

  logic [1:0]    htrans;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [31:0]   hwdata;
  logic [31:0]   rdata;
  logic [1:0]    bresp, rresp;

  assign wr_pend   = aw_full & w_full;
  assign rd_pend   = ar_full;
  assign pick_wr   = (state == S_IDLE) & wr_pend
                   & (~rd_pend | last_rd);
  assign pick_rd   = (state == S_IDLE) & rd_pend
                   & ~pick_wr;
  assign addr_done = (state == S_ADDR) & bus.HREADY;
  assign data_done = (state == S_DATA) & bus.HREADY;

  // strobe pattern to AHB size and low address bits
  always_comb begin
    strb_ok   = 1'b1;
    strb_size = 3'b010;
    strb_lo   = 2'b00;
    unique case (w_strb)
      4'b1111: ;
      4'b0011: strb_size = 3'b001;
      4'b1100: begin
        strb_size = 3'b001;
        strb_lo   = 2'b10;
      end
      4'b0001: strb_size = 3'b000;
      4'b0010: begin
        strb_size = 3'b000;
        strb_lo   = 2'b01;
      end
      4'b0100: begin
        strb_size = 3'b000;
        strb_lo   = 2'b10;
      end
      4'b1000: begin
        strb_size = 3'b000;
        strb_lo   = 2'b11;
      end
      default: strb_ok = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (pick_wr)
          state_nx = strb_ok ? S_ADDR : S_WR_RESP;
        else if (pick_rd)
          state_nx = S_ADDR;
      end
      S_ADDR: begin
        if (bus.HREADY) state_nx = S_DATA;
      end
      S_DATA: begin
        if (bus.HREADY)
          state_nx = cur_wr ? S_WR_RESP : S_RD_RESP;
      end
      S_WR_RESP: begin
        if (bus.S_AXI_BREADY) state_nx = S_IDLE;
      end
      S_RD_RESP: begin
        if (bus.S_AXI_RREADY) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // handshake outputs decoded from state and slots
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    if (!ARESET && state == S_IDLE) begin
      awready = ~aw_full;
      wready  = ~w_full;
      arready = ~ar_full;
    end
    if (state == S_WR_RESP) bvalid = 1'b1;
    if (state == S_RD_RESP) rvalid = 1'b1;
  end

  // single-beat AW/W/AR holding slots
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (bus.S_AXI_AWVALID && awready) begin
        aw_full <= 1'b1;
        aw_addr <= bus.S_AXI_AWADDR[AW-1:2];
      end else if (bvalid && bus.S_AXI_BREADY) begin
        aw_full <= 1'b0;
      end
      if (bus.S_AXI_WVALID && wready) begin
        w_full <= 1'b1;
        w_data <= bus.S_AXI_WDATA;
        w_strb <= bus.S_AXI_WSTRB;
      end else if (bvalid && bus.S_AXI_BREADY) begin
        w_full <= 1'b0;
      end
      if (bus.S_AXI_ARVALID && arready) begin
        ar_full <= 1'b1;
        ar_addr <= bus.S_AXI_ARADDR[AW-1:2];
      end else if (rvalid && bus.S_AXI_RREADY) begin
        ar_full <= 1'b0;
      end
    end
  end

  // AHB address/data phase registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      htrans  <= 2'b00;
      haddr   <= '0;
      hwrite  <= 1'b0;
      hsize   <= 3'b000;
      hwdata  <= '0;
      cur_wr  <= 1'b0;
      last_rd <= 1'b1;
    end else begin
      unique case (1'b1)
        pick_wr: begin
          cur_wr <= 1'b1;
          if (strb_ok) begin
            htrans  <= 2'b10;
            haddr   <= {aw_addr, strb_lo};
            hwrite  <= 1'b1;
            hsize   <= strb_size;
            last_rd <= 1'b0;
          end
        end
        pick_rd: begin
          cur_wr  <= 1'b0;
          htrans  <= 2'b10;
          haddr   <= {ar_addr, 2'b00};
          hwrite  <= 1'b0;
          hsize   <= 3'b010;
          last_rd <= 1'b1;
        end
        addr_done: begin
          htrans <= 2'b00;
          if (cur_wr) hwdata <= w_data;
        end
        default: ;
      endcase
    end
  end

  // AXI response registers, stable while VALID
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bresp <= 2'b00;
      rresp <= 2'b00;
      rdata <= '0;
    end else begin
      unique case (1'b1)
        pick_wr && !strb_ok: bresp <= 2'b10;
        data_done && cur_wr: begin
          bresp <= bus.HRESP ? 2'b10 : 2'b00;
        end
        data_done && !cur_wr: begin
          rresp <= bus.HRESP ? 2'b10 : 2'b00;
          rdata <= bus.HRESP ? '0 : bus.HRDATA;
        end
        default: ;
      endcase
    end
  end

  assign bus.S_AXI_AWREADY = awready;
  assign bus.S_AXI_WREADY  = wready;
  assign bus.S_AXI_ARREADY = arready;
  assign bus.S_AXI_BVALID  = bvalid;
  assign bus.S_AXI_BRESP   = bresp;
  assign bus.S_AXI_RVALID  = rvalid;
  assign bus.S_AXI_RRESP   = rresp;
  assign bus.S_AXI_RDATA   = rdata;
  assign bus.HADDR         = haddr;
  assign bus.HTRANS        = htrans;
  assign bus.HWRITE        = hwrite;
  assign bus.HSIZE         = hsize;
  assign bus.HBURST        = 3'b000;
  assign bus.HPROT         = C_HPROT;
  assign bus.HWDATA        = hwdata;

endmodule

// File: tb/tb_axi4lite_to_ahb_bridge.sv
// Scoreboard bench for the AXI4-Lite to AHB-Lite
// bridge with a small AHB slave memory model.
module tb_axi4lite_to_ahb_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  axi4lite_to_ahb_bridge_if #(.C_ADDR_WIDTH(32)) axi ();

  axi4lite_to_ahb_bridge #(
    .C_ADDR_WIDTH(32),
    .C_DATA_WIDTH(32),
    .C_HPROT(4'b0011)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .bus(axi)
  );

  txn_t       exp_t[$];
  logic [1:0] exp_b[$];
  rsp_t       exp_r[$];
  int checks = 0;
  int fails  = 0;

  logic [31:0] mem [0:63];

  // AHB slave model state and per-address config
  int          ph = 0;
  int          acnt = 0;
  int          k = 0;
  int          nseq = 0;
  txn_t        st;
  logic [31:0] a_addr = 0;
  logic        a_wr = 0;
  logic [2:0]  a_size = 0;
  logic [31:0] a_wdata = 0;
  logic [3:0]  a_mask;
  bit          d_err = 0;
  int          d_waits = 0;
  bit          cfg_en = 0;
  logic [31:0] cfg_addr = 0;
  int          cfg_waits = 0;
  bit          cfg_err = 0;
  int          cfg_aw = 0;

  task automatic push_t(input logic [31:0] a,
                        input logic w,
                        input logic [2:0] s,
                        input logic [31:0] d);
    txn_t t;
    t.addr = a; t.wr = w; t.size = s; t.wdata = d;
    exp_t.push_back(t);
  endtask

  task automatic push_r(input logic [1:0] r,
                        input logic [31:0] d);
    rsp_t x;
    x.resp = r; x.data = d;
    exp_r.push_back(x);
  endtask

  // AHB slave: answers transfers, checks address and data phases
  always @(negedge ACLK) begin
    if (ARESET) begin
      ph = 0; acnt = 0;
      axi.HREADY = 1'b1; axi.HRESP = 1'b0;
      axi.HRDATA = '0;
    end else if (ph == 2) begin
      checks++;
      if (axi.HTRANS !== 2'b00 || axi.HADDR !== a_addr) begin
        fails++;
        $display("FAIL data_phase: HTRANS=%b HADDR=%h, required 00 %h",
                 axi.HTRANS, axi.HADDR, a_addr);
      end
      if (a_wr) begin
        checks++;
        if (axi.HWDATA !== a_wdata) begin
          fails++;
          $display("FAIL hwdata: got %h, required %h",
                   axi.HWDATA, a_wdata);
        end
      end
      if (k < d_waits) begin
        axi.HREADY = 1'b0; axi.HRESP = 1'b0;
      end else if (d_err && k == d_waits) begin
        axi.HREADY = 1'b0; axi.HRESP = 1'b1;
      end else begin
        axi.HREADY = 1'b1; axi.HRESP = d_err;
        if (!a_wr) begin
          axi.HRDATA = d_err ? 32'hDEADBEEF : mem[a_addr[7:2]];
        end else if (!d_err) begin
          case (a_size)
            3'b010: a_mask = 4'hF;
            3'b001: a_mask = a_addr[1] ? 4'hC : 4'h3;
            default: a_mask = 4'b0001 << a_addr[1:0];
          endcase
          for (int b = 0; b < 4; b++)
            if (a_mask[b])
              mem[a_addr[7:2]][8*b+:8] = axi.HWDATA[8*b+:8];
        end
        ph = 0;
      end
      k++;
    end else if (axi.HTRANS === 2'b10) begin
      checks++;
      if (ph == 0) begin
        nseq++;
        if (exp_t.size() == 0) begin
          fails++;
          $display("FAIL unexpected_nonseq: HADDR=%h, required no transfer",
                   axi.HADDR);
        end else begin
          st = exp_t.pop_front();
          a_addr = st.addr; a_wr = st.wr;
          a_size = st.size; a_wdata = st.wdata;
          if (axi.HADDR !== st.addr || axi.HWRITE !== st.wr ||
              axi.HSIZE !== st.size || axi.HBURST !== 3'b000 ||
              axi.HPROT !== 4'b0011) begin
            fails++;
            $display("FAIL addr_phase: %h/%b/%b/%b/%b, required %h/%b/%b/000/0011",
                     axi.HADDR, axi.HWRITE, axi.HSIZE, axi.HBURST,
                     axi.HPROT, st.addr, st.wr, st.size);
          end
        end
        ph = 1; acnt = 0;
      end else begin
        if (axi.HADDR !== a_addr || axi.HWRITE !== a_wr ||
            axi.HSIZE !== a_size) begin
          fails++;
          $display("FAIL addr_hold: %h/%b/%b, required %h/%b/%b",
                   axi.HADDR, axi.HWRITE, axi.HSIZE,
                   a_addr, a_wr, a_size);
        end
      end
      if (acnt < cfg_aw) begin
        axi.HREADY = 1'b0; acnt++;
      end else begin
        axi.HREADY = 1'b1; ph = 2; k = 0;
        d_err   = cfg_en && a_addr == cfg_addr && cfg_err;
        d_waits = (cfg_en && a_addr == cfg_addr) ? cfg_waits : 0;
      end
    end else begin
      axi.HREADY = 1'b1; axi.HRESP = 1'b0;
    end
  end

  // response scoreboard
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
        checks++;
        if (exp_b.size() == 0) begin
          fails++;
          $display("FAIL unexpected_b: BRESP=%b, required none",
                   axi.S_AXI_BRESP);
        end else if (axi.S_AXI_BRESP !== exp_b[0]) begin
          fails++;
          $display("FAIL bresp: got %b, required %b",
                   axi.S_AXI_BRESP, exp_b[0]);
        end
        if (exp_b.size() != 0) void'(exp_b.pop_front());
      end
      if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
        checks++;
        if (exp_r.size() == 0) begin
          fails++;
          $display("FAIL unexpected_r: RDATA=%h, required none",
                   axi.S_AXI_RDATA);
        end else if (axi.S_AXI_RRESP !== exp_r[0].resp ||
                     axi.S_AXI_RDATA !== exp_r[0].data) begin
          fails++;
          $display("FAIL rresp: got %b/%h, required %b/%h",
                   axi.S_AXI_RRESP, axi.S_AXI_RDATA,
                   exp_r[0].resp, exp_r[0].data);
        end
        if (exp_r.size() != 0) void'(exp_r.pop_front());
      end
    end
  end

  task automatic axi_issue(input bit dw, input bit dr,
                           input logic [31:0] awa,
                           input logic [31:0] wd,
                           input logic [3:0] sb,
                           input int wlead,
                           input logic [31:0] ara);
    bit aw_p, w_p, ar_p, hs_aw, hs_w, hs_ar;
    int lead, budget;
    aw_p = dw; w_p = dw; ar_p = dr;
    lead = wlead; budget = 50;
    axi.S_AXI_AWADDR = awa;
    axi.S_AXI_WDATA = wd;
    axi.S_AXI_WSTRB = sb;
    axi.S_AXI_ARADDR = ara;
    axi.S_AXI_WVALID = w_p;
    axi.S_AXI_AWVALID = aw_p && lead == 0;
    axi.S_AXI_ARVALID = ar_p;
    while ((aw_p || w_p || ar_p) && budget > 0) begin
      @(negedge ACLK);
      hs_aw = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      hs_w  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      hs_ar = axi.S_AXI_ARVALID && axi.S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (hs_aw) begin aw_p = 0; axi.S_AXI_AWVALID = 0; end
      if (hs_w)  begin w_p = 0;  axi.S_AXI_WVALID = 0;  end
      if (hs_ar) begin ar_p = 0; axi.S_AXI_ARVALID = 0; end
      if (lead > 0) lead--;
      if (lead == 0 && aw_p) axi.S_AXI_AWVALID = 1;
      budget--;
    end
    if (budget == 0) begin
      checks++; fails++;
      $display("FAIL issue_timeout: aw/w/ar pending %b%b%b, required 000",
               aw_p, w_p, ar_p);
      axi.S_AXI_AWVALID = 0; axi.S_AXI_WVALID = 0;
      axi.S_AXI_ARVALID = 0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_t.size() + exp_b.size() + exp_r.size()) != 0
           && n < 200) begin
      @(posedge ACLK); #1; n++;
    end
    checks++;
    if (n >= 200) begin
      fails++;
      $display("FAIL drain_timeout: %0d/%0d/%0d left, required 0/0/0",
               exp_t.size(), exp_b.size(), exp_r.size());
      exp_t.delete(); exp_b.delete(); exp_r.delete();
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY,
         axi.S_AXI_BVALID, axi.S_AXI_RVALID} !== 5'b0) begin
      fails++;
      $display("FAIL reset_hs: aw/w/ar/b/r=%b%b%b%b%b, required 00000",
               axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY,
               axi.S_AXI_BVALID, axi.S_AXI_RVALID);
    end
    checks++;
    if (axi.HTRANS !== 2'b00 || axi.HWRITE !== 1'b0 ||
        axi.HADDR !== 32'h0 || axi.HWDATA !== 32'h0) begin
      fails++;
      $display("FAIL reset_ahb: %b/%b/%h/%h, required 00/0/0/0",
               axi.HTRANS, axi.HWRITE, axi.HADDR, axi.HWDATA);
    end
    checks++;
    if (axi.S_AXI_RDATA !== 32'h0 || axi.S_AXI_BRESP !== 2'b00 ||
        axi.S_AXI_RRESP !== 2'b00) begin
      fails++;
      $display("FAIL reset_resp: %h/%b/%b, required 0/00/00",
               axi.S_AXI_RDATA, axi.S_AXI_BRESP, axi.S_AXI_RRESP);
    end
    #2 ARESET = 1'b0;
    @(posedge ACLK); #1;
    checks++;
    if (axi.S_AXI_AWREADY !== 1'b1 || axi.S_AXI_ARREADY !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: aw=%b ar=%b, required 1 1",
               axi.S_AXI_AWREADY, axi.S_AXI_ARREADY);
    end
  endtask

  task automatic test_same_cycle();
    int n = 0;
    axi.S_AXI_BREADY = 1'b0;
    push_t(32'h24, 1'b1, 3'b010, 32'h5555AAAA);
    push_t(32'h24, 1'b0, 3'b010, 32'h0);
    exp_b.push_back(2'b00);
    push_r(2'b00, 32'h5555AAAA);
    axi_issue(1, 1, 32'h24, 32'h5555AAAA, 4'hF, 0, 32'h24);
    while (axi.S_AXI_BVALID !== 1'b1 && n < 20) begin
      @(posedge ACLK); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      fails++;
      $display("FAIL bvalid_timeout: BVALID=%b, required 1",
               axi.S_AXI_BVALID);
    end
    repeat (4) begin
      @(negedge ACLK);
      checks++;
      if (axi.S_AXI_BVALID !== 1'b1 || axi.S_AXI_BRESP !== 2'b00 ||
          axi.HTRANS === 2'b10) begin
        fails++;
        $display("FAIL b_stall: BVALID=%b BRESP=%b HTRANS=%b, required 1 00 not-10",
                 axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.HTRANS);
      end
    end
    @(posedge ACLK); #1;
    axi.S_AXI_BREADY = 1'b1;
    wait_done();
  endtask

  task automatic test_basic();
    int n;
    for (int i = 0; i < 4; i++) begin
      push_t(32'(4 * i), 1'b1, 3'b010, 32'(i + 1));
      exp_b.push_back(2'b00);
      axi_issue(1, 0, 32'(4 * i), 32'(i + 1), 4'hF, 0, 32'h0);
      if (i == 0) begin
        n = 0;
        while (axi.S_AXI_BVALID !== 1'b1 && n < 10) begin
          @(posedge ACLK); #1; n++;
        end
        checks++;
        if (n != 3) begin
          fails++;
          $display("FAIL write_latency: %0d cycles, required 3", n);
        end
      end
      wait_done();
    end
    for (int i = 0; i < 4; i++) begin
      push_t(32'(4 * i), 1'b0, 3'b010, 32'h0);
      push_r(2'b00, 32'(i + 1));
      axi_issue(0, 1, 32'h0, 32'h0, 4'h0, 0, 32'(4 * i));
      wait_done();
    end
  endtask

  task automatic test_w_first();
    push_t(32'h12, 1'b1, 3'b000, 32'h00AB0000);
    exp_b.push_back(2'b00);
    axi_issue(1, 0, 32'h10, 32'h00AB0000, 4'b0100, 3, 32'h0);
    wait_done();
    push_t(32'h10, 1'b0, 3'b010, 32'h0);
    push_r(2'b00, 32'h00AB0000);
    axi_issue(0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h10);
    wait_done();
  endtask

  task automatic test_bad_strobe();
    logic [3:0] bad [2];
    int n0;
    bad[0] = 4'b0101;
    bad[1] = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      n0 = nseq;
      exp_b.push_back(2'b10);
      axi_issue(1, 0, 32'h30, 32'h12345678, bad[i], 0, 32'h0);
      wait_done();
      checks++;
      if (nseq != n0) begin
        fails++;
        $display("FAIL bad_strobe_nonseq: %0d transfers, required 0",
                 nseq - n0);
      end
    end
  endtask

  task automatic test_err();
    cfg_en = 1; cfg_addr = 32'h20; cfg_waits = 2;
    cfg_err = 1; cfg_aw = 1;
    push_t(32'h20, 1'b0, 3'b010, 32'h0);
    push_r(2'b10, 32'h0);
    axi_issue(0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h20);
    wait_done();
    cfg_addr = 32'h2C; cfg_waits = 0; cfg_aw = 0;
    push_t(32'h2C, 1'b1, 3'b010, 32'hCAFEF00D);
    exp_b.push_back(2'b10);
    axi_issue(1, 0, 32'h2C, 32'hCAFEF00D, 4'hF, 0, 32'h0);
    wait_done();
    cfg_en = 0; cfg_err = 0;
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    cfg_en = 1; cfg_addr = 32'h28; cfg_waits = 4; cfg_err = 0;
    push_t(32'h28, 1'b0, 3'b010, 32'h0);
    axi_issue(0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h28);
    @(negedge ACLK); #2;
    while (ph != 2 && n < 20) begin
      @(negedge ACLK); #2; n++;
    end
    checks++;
    if (n >= 20) begin
      fails++;
      $display("FAIL data_phase_timeout: ph=%0d, required 2", ph);
    end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if (axi.S_AXI_RVALID !== 1'b0 || axi.HTRANS !== 2'b00 ||
        axi.S_AXI_ARREADY !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: RVALID=%b HTRANS=%b ARREADY=%b, required 0 00 0",
               axi.S_AXI_RVALID, axi.HTRANS, axi.S_AXI_ARREADY);
    end
    @(negedge ACLK); #2;
    ARESET = 1'b0;
    cfg_en = 0;
    @(posedge ACLK); #1;
    checks++;
    if (axi.S_AXI_ARREADY !== 1'b1) begin
      fails++;
      $display("FAIL arready_release: got %b, required 1",
               axi.S_AXI_ARREADY);
    end
    repeat (6) @(posedge ACLK);
    #1;
    push_t(32'h4, 1'b0, 3'b010, 32'h0);
    push_r(2'b00, 32'h2);
    axi_issue(0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h4);
    wait_done();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0;
    axi.S_AXI_WVALID = 1'b0; axi.S_AXI_BREADY = 1'b1;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b1;
    axi.HRDATA = '0; axi.HREADY = 1'b1; axi.HRESP = 1'b0;
    test_reset();
    test_same_cycle();
    test_basic();
    test_w_first();
    test_bad_strobe();
    test_err();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
